// File: rtl/ccd_pkg.sv
// Shared types and constants for the CCD sample-grid capture path.
// Combinational declarations only; no latency, no backpressure.
// Values are not registered.
package ccd_pkg;

    localparam int FRAME_W = 640;
    localparam int FRAME_H = 480;

    typedef logic [9:0] coord_t;
    typedef logic [4:0] gidx_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/sample_grid_ctrl_if.sv
// Pixel-in / sample-out bundle for sample_grid_ctrl.
// Wires only; no latency.
// No backpressure: the pixel stream and the sample store are strobe-driven.
interface sample_grid_ctrl_if;
    import ccd_pkg::*;

    logic   start;
    logic   abort;
    logic   pix_valid;
    coord_t icol;
    coord_t irow;
    logic   ipixel;
    logic   sample_we;
    gidx_t  srow;
    gidx_t  scol;
    logic   opixel;
    logic   busy;
    logic   done;

    modport master (
        output start, abort, pix_valid, icol, irow, ipixel,
        input  sample_we, srow, scol, opixel, busy, done
    );

    modport slave (
        input  start, abort, pix_valid, icol, irow, ipixel,
        output sample_we, srow, scol, opixel, busy, done
    );

endinterface

// File: rtl/sample_grid_ctrl_grid_stepper.sv
// Single-axis grid walker: target coordinate plus grid index.
// tgt/idx/last are combinational (load forces the origin in the same cycle).
// No backpressure; adv steps once per call.
module grid_stepper
    import ccd_pkg::*;
#(
    parameter int ORIGIN = 0,
    parameter int STEP   = 32,
    parameter int COUNT  = 20
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   adv,
    output coord_t tgt,
    output gidx_t  idx,
    output logic   last
);

    localparam coord_t ORG      = coord_t'(ORIGIN);
    localparam coord_t STP      = coord_t'(STEP);
    localparam gidx_t  LAST_IDX = gidx_t'(COUNT - 1);

    coord_t tgt_q;
    gidx_t  idx_q;

    // A reload and a hit on the origin can land together, so the
    // effective position bypasses the registers on load.
    assign tgt  = load ? ORG : tgt_q;
    assign idx  = load ? '0  : idx_q;
    assign last = (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            tgt_q <= '0;
            idx_q <= '0;
        end else if (adv) begin
            if (last) begin
                tgt_q <= ORG;
                idx_q <= '0;
            end else begin
                tgt_q <= tgt + STP;
                idx_q <= idx + gidx_t'(1);
            end
        end else if (load) begin
            tgt_q <= ORG;
            idx_q <= '0;
        end
    end

endmodule

// File: rtl/sample_grid_ctrl.sv
// Captures one GRID_COLS x GRID_ROWS grid of pixels from a CCD raster.
// Latency: sample write one cycle after the hit pixel; done with the final write.
// No backpressure: the sample store must accept every sample_we.
module sample_grid_ctrl
    import ccd_pkg::*;
#(
    parameter int X0        = 0,
    parameter int Y0        = 0,
    parameter int STEP_X    = 32,
    parameter int STEP_Y    = 32,
    parameter int GRID_COLS = 20,
    parameter int GRID_ROWS = 15
) (
    input  logic               clk,
    input  logic               reset,
    sample_grid_ctrl_if.slave  bus
);

    state_t state;
    logic   sample_we_q;
    gidx_t  srow_q;
    gidx_t  scol_q;
    logic   opixel_q;
    logic   busy_q;
    logic   done_q;

    coord_t col_tgt;
    coord_t row_tgt;
    gidx_t  col_idx;
    gidx_t  row_idx;
    logic   col_last;
    logic   row_last;

    logic frame_start;
    logic reload;
    logic capturing;
    logic hit;
    logic final_hit;

    assign frame_start = bus.pix_valid && (bus.icol == '0) && (bus.irow == '0);

    // A frame start while armed or capturing restarts from the origin.
    assign reload    = !bus.abort && frame_start &&
                       ((state == ARMED) || (state == CAPTURE));
    assign capturing = reload || (!bus.abort && (state == CAPTURE));
    assign hit       = capturing && bus.pix_valid &&
                       (bus.icol == col_tgt) && (bus.irow == row_tgt);
    assign final_hit = hit && col_last && row_last;

    grid_stepper #(
        .ORIGIN (X0),
        .STEP   (STEP_X),
        .COUNT  (GRID_COLS)
    ) u_col (
        .clk   (clk),
        .reset (reset),
        .load  (reload),
        .adv   (hit),
        .tgt   (col_tgt),
        .idx   (col_idx),
        .last  (col_last)
    );

    grid_stepper #(
        .ORIGIN (Y0),
        .STEP   (STEP_Y),
        .COUNT  (GRID_ROWS)
    ) u_row (
        .clk   (clk),
        .reset (reset),
        .load  (reload),
        .adv   (hit && col_last),
        .tgt   (row_tgt),
        .idx   (row_idx),
        .last  (row_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sample_we_q <= 1'b0;
            srow_q      <= '0;
            scol_q      <= '0;
            opixel_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            sample_we_q <= hit;
            done_q      <= final_hit;
            if (hit) begin
                srow_q   <= row_idx;
                scol_q   <= col_idx;
                opixel_q <= bus.ipixel;
            end

            if (bus.abort) begin
                state  <= IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state  <= ARMED;
                            busy_q <= 1'b1;
                        end
                    end
                    ARMED: begin
                        if (final_hit) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else if (reload) begin
                            state  <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        if (final_hit) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sample_we = sample_we_q;
    assign bus.srow      = srow_q;
    assign bus.scol      = scol_q;
    assign bus.opixel    = opixel_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_sample_grid_ctrl.sv
// Self-checking bench for sample_grid_ctrl with default parameters.
module tb_sample_grid_ctrl;
    import ccd_pkg::*;

    localparam int SX = 32;
    localparam int SY = 32;
    localparam int GC = 20;
    localparam int GR = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sample_grid_ctrl_if bus();

    sample_grid_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int   r;
        int   c;
        logic p;
        logic last;
    } exp_t;

    typedef struct {
        logic pv;
        int   c;
        int   r;
        logic p;
        logic we;
        int   srow;
        int   scol;
        logic op;
    } vec_t;

    exp_t q[$];
    exp_t me;
    vec_t tbl[6];

    int checks   = 0;
    int failures = 0;
    int m_state  = 0;   // 0 idle, 1 armed, 2 capture
    int m_pushes = 0;
    int writes   = 0;
    int dones    = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic bit on_grid(input int c, input int r);
        return (c % SX == 0) && (c / SX < GC) && (r % SY == 0) && (r / SY < GR);
    endfunction

    // Drive one pixel-clock cycle and advance the reference model.
    task automatic cyc(input logic st, input logic ab, input logic pv,
                       input int c, input int r, input logic p);
        exp_t e;
        @(negedge clk);
        bus.start     = st;
        bus.abort     = ab;
        bus.pix_valid = pv;
        bus.icol      = coord_t'(c);
        bus.irow      = coord_t'(r);
        bus.ipixel    = p;
        if (ab) begin
            m_state = 0;
        end else if (m_state == 0) begin
            if (st) m_state = 1;
        end else begin
            if (pv && c == 0 && r == 0) m_state = 2;
            if (m_state == 2 && pv && on_grid(c, r)) begin
                e.r    = r / SY;
                e.c    = c / SX;
                e.p    = p;
                e.last = (e.c == GC - 1) && (e.r == GR - 1);
                q.push_back(e);
                m_pushes++;
                if (e.last) m_state = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    task automatic raster(input int max_push, input bit mid_start);
        for (int r = 0; r < FRAME_H; r++) begin
            if (r % SY > 1) continue;
            for (int c = 0; c < FRAME_W; c++) begin
                cyc(mid_start && r == 65 && c == 3, 1'b0, 1'b1, c, r,
                    1'($urandom_range(0, 1)));
                if (m_pushes >= max_push) return;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.sample_we) begin
                writes++;
                if (bus.done) dones++;
                if (q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    me = q.pop_front();
                    check("sb_srow", int'(bus.srow), me.r);
                    check("sb_scol", int'(bus.scol), me.c);
                    check("sb_opixel", int'(bus.opixel), int'(me.p));
                    check("sb_done", int'(bus.done), int'(me.last));
                end
            end else if (bus.done) begin
                dones++;
                check("done_without_write", 1, 0);
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1,  5, 0, 1'b1, 1'b0, 0, 0, 1'b0};
        tbl[1] = '{1'b1,  0, 0, 1'b1, 1'b1, 0, 0, 1'b1};
        tbl[2] = '{1'b1, 32, 0, 1'b0, 1'b1, 0, 1, 1'b0};
        tbl[3] = '{1'b0, 64, 0, 1'b1, 1'b0, 0, 0, 1'b0};
        tbl[4] = '{1'b1, 64, 1, 1'b1, 1'b0, 0, 0, 1'b0};
        tbl[5] = '{1'b1, 64, 0, 1'b1, 1'b1, 0, 2, 1'b1};

        bus.start = 1'b0; bus.abort = 1'b0; bus.pix_valid = 1'b0;
        bus.icol = '0; bus.irow = '0; bus.ipixel = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_we", int'(bus.sample_we), 0);
        check("rst_srow", int'(bus.srow), 0);
        check("rst_scol", int'(bus.scol), 0);
        check("rst_opixel", int'(bus.opixel), 0);
        reset = 1'b0;

        // Directed vectors: armed, frame-start sample, pix_valid gating.
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        sample();
        check("busy_after_start", int'(bus.busy), 1);
        foreach (tbl[i]) begin
            cyc(1'b0, 1'b0, tbl[i].pv, tbl[i].c, tbl[i].r, tbl[i].p);
            sample();
            check($sformatf("tbl%0d_we", i), int'(bus.sample_we), int'(tbl[i].we));
            check($sformatf("tbl%0d_busy", i), int'(bus.busy), 1);
            if (tbl[i].we) begin
                check($sformatf("tbl%0d_srow", i), int'(bus.srow), tbl[i].srow);
                check($sformatf("tbl%0d_scol", i), int'(bus.scol), tbl[i].scol);
                check($sformatf("tbl%0d_op", i), int'(bus.opixel), int'(tbl[i].op));
            end
        end
        for (int c = 96; c < GC * SX; c += SX) begin
            cyc(1'b0, 1'b0, 1'b1, c, 0, 1'b0);
            sample();
            check("row0_we", int'(bus.sample_we), 1);
            check("row0_scol", int'(bus.scol), c / SX);
        end
        cyc(1'b0, 1'b0, 1'b1, 0, 32, 1'b0);
        sample();
        check("r1c0_scol", int'(bus.scol), 0);
        check("r1c0_srow", int'(bus.srow), 1);
        cyc(1'b0, 1'b0, 1'b1, 32, 32, 1'b0);
        sample();
        check("r1c1_scol", int'(bus.scol), 1);
        cyc(1'b0, 1'b0, 1'b1, 64, 32, 1'b1);
        sample();
        check("hit64_32_we", int'(bus.sample_we), 1);
        check("hit64_32_srow", int'(bus.srow), 1);
        check("hit64_32_scol", int'(bus.scol), 2);
        check("hit64_32_op", int'(bus.opixel), 1);

        // abort beats a hit and start in the same cycle
        cyc(1'b1, 1'b1, 1'b1, 96, 32, 1'b1);
        sample();
        check("abort_hit_we", int'(bus.sample_we), 0);
        check("abort_hit_busy", int'(bus.busy), 0);
        check("abort_hit_done", int'(bus.done), 0);
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
        sample();
        check("idle_fs_we", int'(bus.sample_we), 0);

        // abort together with start while armed
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        sample();
        check("armed_busy", int'(bus.busy), 1);
        cyc(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        sample();
        check("abort_start_busy", int'(bus.busy), 0);
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
        sample();
        check("after_abort_fs_we", int'(bus.sample_we), 0);

        // Full raster; a start pulse mid-capture must be ignored.
        idle(2);
        q.delete();
        writes = 0; dones = 0; m_pushes = 0;
        mon_en = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        raster(1000, 1'b1);
        idle(3);
        check("full_writes", writes, GC * GR);
        check("full_dones", dones, 1);
        check("full_q_empty", q.size(), 0);
        check("full_busy", int'(bus.busy), 0);

        // Frame restart after 100 samples.
        writes = 0; dones = 0; m_pushes = 0;
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        raster(100, 1'b0);
        raster(1000, 1'b0);
        idle(3);
        check("restart_writes", writes, 100 + GC * GR);
        check("restart_dones", dones, 1);
        check("restart_q_empty", q.size(), 0);

        // Reset mid-capture discards progress.
        writes = 0; dones = 0; m_pushes = 0;
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        raster(30, 1'b0);
        idle(2);
        check("pre_reset_writes", writes, 30);
        check("pre_reset_busy", int'(bus.busy), 1);
        @(negedge clk);
        reset = 1'b1;
        m_state = 0;
        sample();
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_we", int'(bus.sample_we), 0);
        check("midrst_srow", int'(bus.srow), 0);
        check("midrst_scol", int'(bus.scol), 0);
        @(negedge clk);
        reset = 1'b0;
        writes = 0;
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32, 0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 64, 0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 0, 32, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 32, 32, 1'b1);
        idle(2);
        check("post_reset_no_writes", writes, 0);
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
        idle(2);
        check("post_reset_fs_write", writes, 1);

        // pix_valid low across every target yields nothing.
        writes = 0;
        for (int r = 0; r < GR; r++)
            for (int c = 0; c < GC; c++)
                cyc(1'b0, 1'b0, 1'b0, c * SX, r * SY, 1'b1);
        idle(2);
        check("pv_low_writes", writes, 0);
        check("pv_low_busy", int'(bus.busy), 1);
        cyc(1'b0, 1'b0, 1'b1, 32, 0, 1'b1);
        idle(2);
        check("pv_low_resume", writes, 1);
        cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        sample();
        check("final_abort_busy", int'(bus.busy), 0);
        check("final_q_empty", q.size(), 0);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sample_grid_ctrl.md
SAMPLE_GRID_CTRL -- requirements
Module: sample_grid_ctrl

Interface
REQ-001 Parameter X0, default 0: column of the first grid sample.
REQ-002 Parameter Y0, default 0: row of the first grid sample.
REQ-003 Parameter STEP_X, default 32: column pitch between samples.
REQ-004 Parameter STEP_Y, default 32: row pitch between samples.
REQ-005 Parameter GRID_COLS, default 20 (max 32): samples per grid row.
REQ-006 Parameter GRID_ROWS, default 15 (max 32): grid rows.
REQ-007 clk  in  1  sole clock; all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  one-cycle request to capture one grid; ignored unless IDLE.
REQ-010 abort  in  1  one-cycle request to cancel capture; forces IDLE.
REQ-011 pix_valid  in  1  CCD pixel strobe; icol/irow/ipixel qualified by it.
REQ-012 icol  in  10  column index of the current pixel.
REQ-013 irow  in  10  row index of the current pixel.
REQ-014 ipixel  in  1  current pixel value.
REQ-015 sample_we  out  1  one-cycle write strobe to the sample store.
REQ-016 srow  out  5  grid row address of the write.
REQ-017 scol  out  5  grid column address of the write.
REQ-018 opixel  out  1  sampled pixel value for the write.
REQ-019 busy  out  1  high in ARMED or CAPTURE.
REQ-020 done  out  1  one-cycle pulse when the last sample is written.

Function
REQ-021 States: IDLE, ARMED, CAPTURE; 2-bit state register.
REQ-022 IDLE -> ARMED on start; ARMED -> CAPTURE on pix_valid with icol==0 and irow==0 (frame start).
REQ-023 The frame-start pixel SHALL itself be sampled if X0==0 and Y0==0.
REQ-024 Target registers tgt_col/tgt_row (10 bit) SHALL load X0/Y0, and grid counters col_idx/row_idx SHALL load 0, on entry to CAPTURE.
REQ-025 In CAPTURE, a hit is pix_valid and icol==tgt_col and irow==tgt_row.
REQ-026 On a hit: sample_we=1, scol=col_idx, srow=row_idx, opixel=ipixel, all registered, appearing exactly one cycle after the hit pixel.
REQ-027 After a hit with col_idx<GRID_COLS-1: col_idx+1, tgt_col+STEP_X.
REQ-028 After a hit with col_idx==GRID_COLS-1 and row_idx<GRID_ROWS-1: col_idx=0, tgt_col=X0, row_idx+1, tgt_row+STEP_Y.
REQ-029 After a hit on the last cell (GRID_COLS-1, GRID_ROWS-1): CAPTURE -> IDLE; done pulses in the same cycle as the final sample_we.
REQ-030 Target additions SHALL be 10-bit with no wrap; parameters are constrained so that X0+(GRID_COLS-1)*STEP_X<1024 and Y0+(GRID_ROWS-1)*STEP_Y<1024.
REQ-031 A frame start (icol==0, irow==0, pix_valid) in CAPTURE before completion SHALL restart the capture from the origin per REQ-024; no done pulse is issued for the aborted frame.
REQ-032 abort SHALL win over start, a hit, and a frame start in the same cycle; next state IDLE, no sample_we or done.
REQ-033 start while busy SHALL be ignored.
REQ-034 pix_valid low SHALL never produce a hit, regardless of icol/irow.
REQ-035 busy SHALL be a registered decode of state.

Reset
REQ-036 reset SHALL set state=IDLE, busy=0, done=0, sample_we=0, srow=0, scol=0, opixel=0, and all counters and targets to 0.
REQ-037 reset mid-CAPTURE SHALL discard progress; the next start requires a new frame start.

Structure
REQ-038 A shared package ccd_pkg SHALL hold the state enum, the 10-bit coordinate type, the 5-bit grid index type, and the FRAME_W=640/FRAME_H=480 constants.
REQ-039 One sub-module, grid_stepper (target/index counter for a single axis, instantiated twice), is natural; the FSM stays in the top module.

Verification
REQ-040 Defaults, start, then a full 640x480 raster -> 300 sample_we pulses at (icol,irow)=(32c,32r), addresses (r,c) in raster order, done with the 300th write.
REQ-041 Hit at icol=64, irow=32 with ipixel=1 -> next cycle sample_we=1, srow=1, scol=2, opixel=1.
REQ-042 Frame restarts after 100 samples -> capture restarts at (0,0), 300 further writes, then exactly one done.
REQ-043 abort and start asserted together in ARMED -> IDLE, busy=0 the next cycle.
REQ-044 reset asserted mid-CAPTURE, then start -> no writes until the next (0,0) pixel.
REQ-045 pix_valid held low with icol/irow stepping through targets -> zero writes.
